// File: rtl/tdr_pkg.sv
// Shared definitions for the JTAG test-data-register bank.
// Provides the capture/shift/update FSM state encoding, the documented
// priority order of the TAP control inputs, and width helper functions.
package tdr_pkg;

    // Capture/shift/update sequencing state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CAP   = 2'd1,
        ST_SHIFT = 2'd2
    } tdr_state_e;

    // Priority ranking when several TAP controls are high together (higher wins)
    localparam int unsigned PRIO_SHIFT   = 32'd2;
    localparam int unsigned PRIO_CAPTURE = 32'd1;
    localparam int unsigned PRIO_UPDATE  = 32'd0;

    // Bit-counter width: must hold 0..WIDTH+1 (WIDTH+1 is the "too long" saturation value)
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 32'd2);
    endfunction

    // Register-index width; never below one bit so a one-register bank still elaborates
    function automatic int unsigned sel_width(input int unsigned num_reg);
        return (num_reg > 32'd1) ? $clog2(num_reg) : 32'd1;
    endfunction

endpackage

// File: rtl/tdr_shift_core.sv
// Shared capture/shift path of the TDR bank.
// Holds the shift register, the 1-bit bypass flop, the shift-length counter,
// the sequencing FSM and the target latched at capture time.
// Ports:
//   TCLK, TRESET                 clock, synchronous active-high reset
//   CaptureDR/ShiftDR/UpdateDR   TAP state decodes (shift > capture > update)
//   SelValid, Sel                target selection, sampled only on capture
//   SI                           serial in
//   capData                      slice to load on capture (muxed by the top)
//   SO                           serial out
//   tgtIdx                       latched register index
//   shregOut                     current shift-register contents
//   updOk / updBad               this-cycle update accepted / rejected (register target only)
module tdr_shift_core
    import tdr_pkg::*;
#(
    parameter int unsigned WIDTH   = 33,
    parameter int unsigned NUM_REG = 4,
    parameter int unsigned SEL_W   = sel_width(NUM_REG)
) (
    input  logic             TCLK,
    input  logic             TRESET,
    input  logic             CaptureDR,
    input  logic             ShiftDR,
    input  logic             UpdateDR,
    input  logic             SelValid,
    input  logic [SEL_W-1:0] Sel,
    input  logic             SI,
    input  logic [WIDTH-1:0] capData,
    output logic             SO,
    output logic [SEL_W-1:0] tgtIdx,
    output logic [WIDTH-1:0] shregOut,
    output logic             updOk,
    output logic             updBad
);

    localparam int unsigned      CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(WIDTH + 32'd1);
    localparam logic [SEL_W:0]   NUM_REG_L = (SEL_W + 1)'(NUM_REG);

    tdr_state_e       state_r;
    logic [WIDTH-1:0] shiftReg_r;
    logic             bypass_r;
    logic [CNT_W-1:0] bitCnt_r;
    logic             tgtReg_r;
    logic [SEL_W-1:0] tgtIdx_r;
    logic             selInRange_s;
    logic             updOk_s;
    logic             updBad_s;

    // An out-of-range index with SelValid set falls back to bypass
    assign selInRange_s = ({1'b0, Sel} < NUM_REG_L);

    // Sequencing FSM, shift/bypass data path and shift-length counter
    always_ff @(posedge TCLK) begin
        if (TRESET) begin
            state_r    <= ST_IDLE;
            shiftReg_r <= '0;
            bypass_r   <= 1'b0;
            bitCnt_r   <= '0;
            // After reset the target is register 0, so a stray update is flagged
            tgtReg_r   <= 1'b1;
            tgtIdx_r   <= '0;
        end else if (ShiftDR) begin
            // Data always moves so TDO stays live; only an armed scan counts bits
            if (state_r == ST_IDLE) begin
                bitCnt_r <= '0;
            end else begin
                state_r <= ST_SHIFT;
                if (bitCnt_r != CNT_SAT) begin
                    bitCnt_r <= bitCnt_r + CNT_W'(1);
                end
            end
            if (tgtReg_r) begin
                shiftReg_r <= {SI, shiftReg_r[WIDTH-1:1]};
            end else begin
                bypass_r <= SI;
            end
        end else if (CaptureDR) begin
            state_r  <= ST_CAP;
            bitCnt_r <= '0;
            tgtReg_r <= SelValid && selInRange_s;
            tgtIdx_r <= Sel;
            if (SelValid && selInRange_s) begin
                shiftReg_r <= capData;
            end else begin
                bypass_r <= 1'b0;
            end
        end else if (UpdateDR) begin
            state_r <= ST_IDLE;
        end
    end

    // Update verdict: only a register target after exactly WIDTH armed shifts is accepted
    always_comb begin
        updOk_s  = 1'b0;
        updBad_s = 1'b0;
        if (UpdateDR && !ShiftDR && !CaptureDR && tgtReg_r) begin
            if ((state_r == ST_SHIFT) && (bitCnt_r == CNT_FULL)) begin
                updOk_s = 1'b1;
            end else begin
                updBad_s = 1'b1;
            end
        end else begin
            updOk_s  = 1'b0;
            updBad_s = 1'b0;
        end
    end

    assign SO       = tgtReg_r ? shiftReg_r[0] : bypass_r;
    assign tgtIdx   = tgtIdx_r;
    assign shregOut = shiftReg_r;
    assign updOk    = updOk_s;
    assign updBad   = updBad_s;

endmodule

// File: rtl/tdr_bank.sv
// Bank of NUM_REG JTAG test data registers sharing one capture/shift/update path.
// Adds a bypass path, shift-length checking that protects the parallel outputs
// from short/long scans, and per-register one-cycle update strobes.
// Ports:
//   TCLK, TRESET                 clock, synchronous active-high reset
//   CaptureDR/ShiftDR/UpdateDR   TAP state decodes
//   SelValid, Sel                IR-decoded target (SelValid=0 selects bypass)
//   ClrErr                       clears LenErr (a simultaneous new error wins)
//   SI / SO                      TDI / TDO
//   PI / PO                      parallel capture / update data, slice k = [k*WIDTH +: WIDTH]
//   UpdStrobe                    one-cycle pulse on the register just written
//   LenErr                       sticky wrong-shift-count flag
module tdr_bank
    import tdr_pkg::*;
#(
    parameter  int unsigned WIDTH    = 33,
    parameter  int unsigned NUM_REG  = 4,
    parameter  int unsigned CAP_MODE = 0,
    localparam int unsigned SEL_W    = sel_width(NUM_REG)
) (
    input  logic                     TCLK,
    input  logic                     TRESET,
    input  logic                     CaptureDR,
    input  logic                     ShiftDR,
    input  logic                     UpdateDR,
    input  logic                     SelValid,
    input  logic [SEL_W-1:0]         Sel,
    input  logic                     ClrErr,
    input  logic                     SI,
    input  logic [NUM_REG*WIDTH-1:0] PI,
    output logic                     SO,
    output logic [NUM_REG*WIDTH-1:0] PO,
    output logic [NUM_REG-1:0]       UpdStrobe,
    output logic                     LenErr
);

    localparam logic [SEL_W:0] NUM_REG_L = (SEL_W + 1)'(NUM_REG);

    logic [WIDTH-1:0]   poArr_r [NUM_REG];
    logic [WIDTH-1:0]   piArr_s [NUM_REG];
    logic [NUM_REG-1:0] updStrobe_r;
    logic               lenErr_r;
    logic [WIDTH-1:0]   capData_s;
    logic [SEL_W-1:0]   tgtIdx_s;
    logic [WIDTH-1:0]   shreg_s;
    logic               updOk_s;
    logic               updBad_s;

    for (genvar k = 0; k < NUM_REG; k++) begin : g_slice
        assign piArr_s[k]               = PI[k*WIDTH +: WIDTH];
        assign PO[k*WIDTH +: WIDTH]     = poArr_r[k];
    end

    // Capture source: PI slice, or current PO slice for readback; Sel is live here
    always_comb begin
        capData_s = '0;
        if ({1'b0, Sel} < NUM_REG_L) begin
            if (CAP_MODE != 32'd0) begin
                capData_s = poArr_r[Sel];
            end else begin
                capData_s = piArr_s[Sel];
            end
        end else begin
            capData_s = '0;
        end
    end

    tdr_shift_core #(
        .WIDTH   (WIDTH),
        .NUM_REG (NUM_REG),
        .SEL_W   (SEL_W)
    ) u_core (
        .TCLK      (TCLK),
        .TRESET    (TRESET),
        .CaptureDR (CaptureDR),
        .ShiftDR   (ShiftDR),
        .UpdateDR  (UpdateDR),
        .SelValid  (SelValid),
        .Sel       (Sel),
        .SI        (SI),
        .capData   (capData_s),
        .SO        (SO),
        .tgtIdx    (tgtIdx_s),
        .shregOut  (shreg_s),
        .updOk     (updOk_s),
        .updBad    (updBad_s)
    );

    // Parallel output registers, written only on an accepted update
    always_ff @(posedge TCLK) begin
        for (int k = 0; k < NUM_REG; k++) begin
            if (TRESET) begin
                poArr_r[k] <= '0;
            end else if (updOk_s && (tgtIdx_s == SEL_W'(k))) begin
                poArr_r[k] <= shreg_s;
            end
        end
    end

    // Update strobes: one-hot, high for exactly the cycle after the write edge
    always_ff @(posedge TCLK) begin
        for (int k = 0; k < NUM_REG; k++) begin
            if (TRESET) begin
                updStrobe_r[k] <= 1'b0;
            end else begin
                updStrobe_r[k] <= updOk_s && (tgtIdx_s == SEL_W'(k));
            end
        end
    end

    // Sticky length-error flag; a new error beats a simultaneous clear
    always_ff @(posedge TCLK) begin
        if (TRESET) begin
            lenErr_r <= 1'b0;
        end else if (updBad_s) begin
            lenErr_r <= 1'b1;
        end else if (ClrErr) begin
            lenErr_r <= 1'b0;
        end
    end

    assign UpdStrobe = updStrobe_r;
    assign LenErr    = lenErr_r;

endmodule

// File: tb/tb_tdr_bank.sv
// Directed self-checking bench for tdr_bank (two instances: PI capture and PO readback).
module tb_tdr_bank;

    localparam int W = 33;
    localparam int N = 4;

    logic           TCLK;
    logic           TRESET;
    logic           CaptureDR;
    logic           ShiftDR;
    logic           UpdateDR;
    logic           SelValid;
    logic [1:0]     Sel;
    logic           ClrErr;
    logic           SI;
    logic [N*W-1:0] PI;
    logic           SO0, SO1;
    logic [N*W-1:0] PO0, PO1;
    logic [N-1:0]   UpdStrobe0, UpdStrobe1;
    logic           LenErr0, LenErr1;

    int nAssert = 0;
    int nFail   = 0;

    tdr_bank #(.WIDTH(W), .NUM_REG(N), .CAP_MODE(0)) dut0 (
        .TCLK(TCLK), .TRESET(TRESET), .CaptureDR(CaptureDR), .ShiftDR(ShiftDR),
        .UpdateDR(UpdateDR), .SelValid(SelValid), .Sel(Sel), .ClrErr(ClrErr),
        .SI(SI), .PI(PI), .SO(SO0), .PO(PO0), .UpdStrobe(UpdStrobe0), .LenErr(LenErr0)
    );

    tdr_bank #(.WIDTH(W), .NUM_REG(N), .CAP_MODE(1)) dut1 (
        .TCLK(TCLK), .TRESET(TRESET), .CaptureDR(CaptureDR), .ShiftDR(ShiftDR),
        .UpdateDR(UpdateDR), .SelValid(SelValid), .Sel(Sel), .ClrErr(ClrErr),
        .SI(SI), .PI(PI), .SO(SO1), .PO(PO1), .UpdStrobe(UpdStrobe1), .LenErr(LenErr1)
    );

    initial TCLK = 1'b0;
    always #5 TCLK = ~TCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge TCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic capture(input logic sv, input logic [1:0] s);
        SelValid  = sv;
        Sel       = s;
        CaptureDR = 1'b1;
        tick();
        CaptureDR = 1'b0;
    endtask

    task automatic shiftN(input int n, input logic si);
        ShiftDR = 1'b1;
        SI      = si;
        repeat (n) tick();
        ShiftDR = 1'b0;
    endtask

    task automatic update();
        UpdateDR = 1'b1;
        tick();
        UpdateDR = 1'b0;
    endtask

    logic [W-1:0]   v;
    logic [W-1:0]   obs;
    logic [2:0]     byObs;
    logic [N*W-1:0] expPo;

    initial begin
        TRESET = 1'b1; CaptureDR = 1'b0; ShiftDR = 1'b0; UpdateDR = 1'b0;
        SelValid = 1'b1; Sel = 2'd0; ClrErr = 1'b0; SI = 1'b0;
        PI = {33'h0_1357_9BDF, 33'h1_2345_6789, 33'h1_0F0F_0F0F, 33'h0_AAAA_5555};
        tick();
        tick();
        TRESET = 1'b0;

        // Reset state
        check("rst_po", PO0, '0);
        check("rst_strobe", {128'd0, UpdStrobe0}, '0);
        check("rst_lenerr", {131'd0, LenErr0}, '0);
        check("rst_so", {131'd0, SO0}, '0);

        // 1: capture slice 2, stream it out, good update; Sel change after capture is ignored
        v = 33'h1_2345_6789;
        capture(1'b1, 2'd2);
        Sel = 2'd0;
        ShiftDR = 1'b1;
        SI = 1'b0;
        for (int i = 0; i < W; i++) begin
            obs[i] = SO0;
            tick();
        end
        ShiftDR = 1'b0;
        check("t1_so_stream", {99'd0, obs}, {99'd0, v});
        update();
        check("t1_po", PO0, '0);
        check("t1_strobe", {128'd0, UpdStrobe0}, {128'd0, 4'b0100});
        check("t1_lenerr", {131'd0, LenErr0}, '0);
        tick();
        check("t1_strobe_gone", {128'd0, UpdStrobe0}, '0);

        // 2: short scan is rejected
        capture(1'b1, 2'd1);
        shiftN(32, 1'b1);
        update();
        check("t2_po", PO0, '0);
        check("t2_strobe", {128'd0, UpdStrobe0}, '0);
        check("t2_lenerr", {131'd0, LenErr0}, {131'd0, 1'b1});
        ClrErr = 1'b1; tick(); ClrErr = 1'b0;
        check("t2_clr", {131'd0, LenErr0}, '0);

        // 3: long scan rejected, then a good scan writes while the error stays sticky
        capture(1'b1, 2'd1);
        shiftN(34, 1'b1);
        update();
        check("t3_long_lenerr", {131'd0, LenErr0}, {131'd0, 1'b1});
        check("t3_long_po", PO0, '0);
        capture(1'b1, 2'd1);
        shiftN(33, 1'b1);
        update();
        expPo = {33'd0, 33'd0, 33'h1_FFFF_FFFF, 33'd0};
        check("t3_good_po", PO0, expPo);
        check("t3_good_strobe", {128'd0, UpdStrobe0}, {128'd0, 4'b0010});
        check("t3_lenerr_sticky", {131'd0, LenErr0}, {131'd0, 1'b1});

        // Error set and clear in the same cycle: set wins
        ClrErr = 1'b1; tick(); ClrErr = 1'b0;
        capture(1'b1, 2'd0);
        UpdateDR = 1'b1; ClrErr = 1'b1;
        tick();
        UpdateDR = 1'b0; ClrErr = 1'b0;
        check("set_beats_clr", {131'd0, LenErr0}, {131'd0, 1'b1});
        ClrErr = 1'b1; tick(); ClrErr = 1'b0;

        // 4: bypass path gives a one-cycle delay and never touches PO or LenErr
        capture(1'b0, 2'd2);
        ShiftDR = 1'b1;
        SI = 1'b1; byObs[0] = SO0; tick();
        SI = 1'b0; byObs[1] = SO0; tick();
        SI = 1'b1; byObs[2] = SO0; tick();
        ShiftDR = 1'b0;
        check("t4_byp_so", {129'd0, byObs}, {129'd0, 3'b010});
        check("t4_byp_last", {131'd0, SO0}, {131'd0, 1'b1});
        update();
        check("t4_po", PO0, expPo);
        check("t4_strobe", {128'd0, UpdStrobe0}, '0);
        check("t4_lenerr", {131'd0, LenErr0}, '0);

        // 5: reset in the middle of a scan discards it
        capture(1'b1, 2'd0);
        shiftN(10, 1'b1);
        TRESET = 1'b1; ShiftDR = 1'b1;
        tick();
        TRESET = 1'b0; ShiftDR = 1'b0;
        check("t5_rst_po", PO0, '0);
        check("t5_rst_lenerr", {131'd0, LenErr0}, '0);
        check("t5_rst_so", {131'd0, SO0}, '0);
        shiftN(23, 1'b1);
        update();
        check("t5_po", PO0, '0);
        check("t5_lenerr", {131'd0, LenErr0}, {131'd0, 1'b1});
        ClrErr = 1'b1; tick(); ClrErr = 1'b0;

        // 6: readback mode - load PO slice 3 then capture it back out
        v = 33'h0_DEAD_BEEF;
        capture(1'b1, 2'd3);
        ShiftDR = 1'b1;
        for (int i = 0; i < W; i++) begin
            SI = v[i];
            tick();
        end
        ShiftDR = 1'b0;
        update();
        check("t6_load_po", PO1, {v, 99'd0});
        check("t6_load_strobe", {128'd0, UpdStrobe1}, {128'd0, 4'b1000});
        capture(1'b1, 2'd3);
        ShiftDR = 1'b1;
        SI = 1'b0;
        for (int i = 0; i < W; i++) begin
            obs[i] = SO1;
            tick();
        end
        ShiftDR = 1'b0;
        check("t6_readback_so", {99'd0, obs}, {99'd0, v});

        // Capture and shift together: the shift is taken and counted
        capture(1'b1, 2'd3);
        CaptureDR = 1'b1; ShiftDR = 1'b1; SI = 1'b0;
        tick();
        CaptureDR = 1'b0; ShiftDR = 1'b0;
        shiftN(32, 1'b0);
        update();
        check("t6_combo_strobe", {128'd0, UpdStrobe1}, {128'd0, 4'b1000});
        check("t6_combo_po", PO1, '0);
        check("t6_combo_lenerr", {131'd0, LenErr1}, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
